// File: rtl/mult_funct3_pkg.sv
// Shared types for the M-extension multiply/divide datapath.
//   mult_funct3_t     : RISC-V funct3 encoding of the MUL/DIV family
//   div_state_t       : divide issue controller state encoding
//   div_cache_entry_t : single-entry divide result cache contents
package mult_funct3_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mult_funct3_t;

    // funct3 bit 1 selects remainder over quotient; bit 0 marks unsigned.
    localparam int unsigned OP_REM_BIT      = 1;
    localparam int unsigned OP_UNSIGNED_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESP   = 3'd4
    } div_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        is_signed;
        logic [31:0] quotient;
        logic [31:0] remainder;
    } div_cache_entry_t;

endpackage

// File: rtl/div_result_cache.sv
// Single-entry divide result cache. A div/rem pair on identical operands
// and signedness shares one divider run.
//   clk, rst          : clock, synchronous active-high reset (invalidates)
//   lkp_*             : operands of the incoming request, lkp_hit is combinational
//   rd_quotient/rd_remainder : stored results
//   upd_*             : write a new entry (sets valid)
module div_result_cache
    import mult_funct3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lkp_rs1,
    input  logic [31:0] lkp_rs2,
    input  logic        lkp_signed,
    output logic        lkp_hit,
    output logic [31:0] rd_quotient,
    output logic [31:0] rd_remainder,
    input  logic        upd_en,
    input  logic [31:0] upd_rs1,
    input  logic [31:0] upd_rs2,
    input  logic        upd_signed,
    input  logic [31:0] upd_quotient,
    input  logic [31:0] upd_remainder
);

    div_cache_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (upd_en) begin
            entry_d.valid     = 1'b1;
            entry_d.rs1       = upd_rs1;
            entry_d.rs2       = upd_rs2;
            entry_d.is_signed = upd_signed;
            entry_d.quotient  = upd_quotient;
            entry_d.remainder = upd_remainder;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry_d;
    end

    assign lkp_hit = entry_q.valid
                   && (entry_q.rs1 == lkp_rs1)
                   && (entry_q.rs2 == lkp_rs2)
                   && (entry_q.is_signed == lkp_signed);

    assign rd_quotient  = entry_q.quotient;
    assign rd_remainder = entry_q.remainder;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller between the execute stage and a multi-cycle,
// non-abortable divider. Latches the request, launches the divider,
// returns the selected result, and short-circuits div/rem pairs through
// a one-entry result cache.
//   clk, rst           : clock, synchronous active-high reset
//   flush              : kill the in-flight request
//   req_*              : request handshake and operands from execute
//   div_*  (out)       : launch pulse and held operands to the divider
//   div_done/quotient/remainder : divider completion
//   resp_*             : result handshake to writeback
//   busy               : state is not IDLE
//
// state  | meaning
// IDLE   | ready for a request
// LAUNCH | div_start pulse, operands held
// WAIT   | divider running, response still wanted
// DRAIN  | divider running after flush, result only fills the cache
// RESP   | result offered to writeback
module div_issue_ctrl
    import mult_funct3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_tag,
    output logic        div_start,
    output logic [2:0]  div_op,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_tag,
    output logic        busy
);

    div_state_t   state_q, state_d;
    mult_funct3_t op_q, op_d;
    logic [31:0]  rs1_q, rs1_d;
    logic [31:0]  rs2_q, rs2_d;
    logic [4:0]   tag_q, tag_d;

    logic         cache_hit;
    logic         cache_upd;
    logic [31:0]  cache_quotient;
    logic [31:0]  cache_remainder;

    // Lookup uses the live request so a hit can skip LAUNCH entirely.
    div_result_cache u_cache (
        .clk           (clk),
        .rst           (rst),
        .lkp_rs1       (req_rs1),
        .lkp_rs2       (req_rs2),
        .lkp_signed    (~req_op[OP_UNSIGNED_BIT]),
        .lkp_hit       (cache_hit),
        .rd_quotient   (cache_quotient),
        .rd_remainder  (cache_remainder),
        .upd_en        (cache_upd),
        .upd_rs1       (rs1_q),
        .upd_rs2       (rs2_q),
        .upd_signed    (~op_q[OP_UNSIGNED_BIT]),
        .upd_quotient  (div_quotient),
        .upd_remainder (div_remainder)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        tag_d      = tag_q;
        req_ready  = 1'b0;
        div_start  = 1'b0;
        resp_valid = 1'b0;
        cache_upd  = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = ~flush;
                if (req_valid && !flush) begin
                    op_d    = mult_funct3_t'(req_op);
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    tag_d   = req_tag;
                    state_d = cache_hit ? S_RESP : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                div_start = 1'b1;
                state_d   = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                // A result arriving alongside flush still fills the cache.
                if (div_done) begin
                    cache_upd = 1'b1;
                    state_d   = flush ? S_IDLE : S_RESP;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (div_done) begin
                    cache_upd = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RESP: begin
                resp_valid = ~flush;
                if (flush || resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= F3_MUL;
            rs1_q   <= '0;
            rs2_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            tag_q   <= tag_d;
        end
    end

    assign div_op       = op_q;
    assign div_dividend = rs1_q;
    assign div_divisor  = rs2_q;

    // Cache only changes in WAIT/DRAIN, so the response is stable in RESP.
    assign resp_data = op_q[OP_REM_BIT] ? cache_remainder : cache_quotient;
    assign resp_tag  = tag_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl. Inputs change and outputs are checked
// just after the falling edge; state advances on the rising edge.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_tag;
    logic        div_start;
    logic [2:0]  div_op;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_tag       (req_tag),
        .div_start     (div_start),
        .div_op        (div_op),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and return all pulses to idle.
    task automatic cyc();
        @(negedge clk);
        rst        = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        div_done   = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
    endtask

    task automatic done(input logic [31:0] q, input logic [31:0] r);
        div_done      = 1'b1;
        div_quotient  = q;
        div_remainder = r;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_rs1 = '0;
        req_rs2 = '0; req_tag = '0; div_done = 1'b0; div_quotient = '0;
        div_remainder = '0; resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        cyc(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_dividend", div_dividend, 0);

        // divu 100/7, miss path latency
        cyc(); req(OP_DIVU, 100, 7, 3); #1;
        chk("a_ready", req_ready, 1);
        chk("a_start_accept", div_start, 0);
        cyc(); #1;
        chk("a_start", div_start, 1);
        chk("a_op", div_op, OP_DIVU);
        chk("a_dividend", div_dividend, 100);
        chk("a_divisor", div_divisor, 7);
        chk("a_busy", busy, 1);
        cyc(); #1;
        chk("a_start_once", div_start, 0);
        cyc(); done(14, 2); #1;
        chk("a_no_early_resp", resp_valid, 0);
        chk("a_held_dividend", div_dividend, 100);
        cyc(); resp_ready = 1'b1; #1;
        chk("a_resp_valid", resp_valid, 1);
        chk("a_resp_data", resp_data, 14);
        chk("a_resp_tag", resp_tag, 3);
        cyc(); #1;
        chk("a_idle", busy, 0);
        chk("a_resp_gone", resp_valid, 0);

        // div -20/3 then rem -20/3 (hit)
        cyc(); req(OP_DIV, 32'hFFFF_FFEC, 3, 5); #1;
        cyc(); #1;
        chk("b_start", div_start, 1);
        cyc(); done(32'hFFFF_FFFA, 32'hFFFF_FFFE); #1;
        cyc(); resp_ready = 1'b1; #1;
        chk("b_div_valid", resp_valid, 1);
        chk("b_div_data", resp_data, 32'hFFFF_FFFA);
        chk("b_div_tag", resp_tag, 5);
        cyc(); req(OP_REM, 32'hFFFF_FFEC, 3, 6); #1;
        chk("b_rem_ready", req_ready, 1);
        cyc(); resp_ready = 1'b1; #1;
        chk("b_rem_no_start", div_start, 0);
        chk("b_rem_valid", resp_valid, 1);
        chk("b_rem_data", resp_data, 32'hFFFF_FFFE);
        chk("b_rem_tag", resp_tag, 6);
        cyc(); #1;
        chk("b_idle", busy, 0);

        // div 100/7 flushed in WAIT, then rem 100/7 hits on the drained result
        cyc(); req(OP_DIV, 100, 7, 7); #1;
        cyc(); #1;
        chk("c_start", div_start, 1);
        cyc(); flush = 1'b1; #1;
        chk("c_wait_no_resp", resp_valid, 0);
        cyc(); #1;
        chk("c_drain_busy", busy, 1);
        chk("c_drain_not_ready", req_ready, 0);
        chk("c_drain_no_resp", resp_valid, 0);
        cyc(); done(14, 2); #1;
        chk("c_drain_busy_done", busy, 1);
        chk("c_drain_no_resp_done", resp_valid, 0);
        cyc(); #1;
        chk("c_idle", busy, 0);
        chk("c_idle_no_resp", resp_valid, 0);
        cyc(); req(OP_REM, 100, 7, 8); #1;
        cyc(); resp_ready = 1'b1; #1;
        chk("c_hit_no_start", div_start, 0);
        chk("c_hit_valid", resp_valid, 1);
        chk("c_hit_data", resp_data, 2);
        chk("c_hit_tag", resp_tag, 8);

        // divu 100/7 then div 100/7: signedness differs, both launch
        cyc(); req(OP_DIVU, 100, 7, 10); #1;
        cyc(); #1;
        chk("d_divu_start", div_start, 1);
        cyc(); done(14, 2); #1;
        cyc(); resp_ready = 1'b1; #1;
        chk("d_divu_data", resp_data, 14);
        cyc(); req(OP_DIV, 100, 7, 11); #1;
        cyc(); #1;
        chk("d_div_start", div_start, 1);
        chk("d_div_op", div_op, OP_DIV);
        cyc(); done(14, 2); #1;
        cyc(); resp_ready = 1'b1; #1;
        chk("d_div_data", resp_data, 14);
        chk("d_div_tag", resp_tag, 11);

        // flush beats req_valid in IDLE
        cyc(); req(OP_DIV, 100, 7, 12); flush = 1'b1; #1;
        chk("e_flush_not_ready", req_ready, 0);
        cyc(); #1;
        chk("e_flush_idle", busy, 0);
        chk("e_flush_no_resp", resp_valid, 0);

        // Back-pressure in RESP; stray div_done must not disturb the result
        cyc(); req(OP_DIV, 100, 7, 13); #1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 2) done(99, 98);
            #1;
            chk("f_stall_valid", resp_valid, 1);
            chk("f_stall_data", resp_data, 14);
            chk("f_stall_tag", resp_tag, 13);
            chk("f_stall_no_start", div_start, 0);
        end
        cyc(); resp_ready = 1'b1; #1;
        chk("f_release_valid", resp_valid, 1);
        chk("f_release_data", resp_data, 14);
        cyc(); resp_ready = 1'b1; #1;
        chk("f_single_handshake", resp_valid, 0);
        chk("f_idle", busy, 0);

        // flush beats resp_ready in RESP
        cyc(); req(OP_REM, 100, 7, 14); #1;
        cyc(); resp_ready = 1'b1; flush = 1'b1; #1;
        chk("g_flush_resp_valid", resp_valid, 0);
        cyc(); #1;
        chk("g_flush_idle", busy, 0);

        // rst in WAIT clears everything including the cache
        cyc(); req(OP_DIVU, 1000, 10, 9); #1;
        cyc(); #1;
        chk("h_start", div_start, 1);
        cyc(); rst = 1'b1; #1;
        cyc(); #1;
        chk("h_rst_idle", busy, 0);
        chk("h_rst_no_resp", resp_valid, 0);
        chk("h_rst_dividend", div_dividend, 0);
        chk("h_rst_op", div_op, 0);
        cyc(); req(OP_REM, 100, 7, 15); #1;
        cyc(); #1;
        chk("h_relaunch", div_start, 1);
        chk("h_relaunch_dividend", div_dividend, 100);
        cyc(); done(14, 2); #1;
        cyc(); resp_ready = 1'b1; #1;
        chk("h_resp_data", resp_data, 2);
        chk("h_resp_tag", resp_tag, 15);
        cyc(); #1;
        chk("h_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
